// File: rtl/fft_output_reorder.sv
// Output stage of the 16-point DIF FFT: captures a bit-reversed 16-lane frame and streams it serially in natural order.
// Optional FFT_REORDER_MAG_EN adds out_mag = re*re + im*im, registered alongside the bin data.
module fft_output_reorder #(
    parameter int WIDTH  = 16,
    parameter int BITREV = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH*16-1:0]   in_real,
    input  logic [WIDTH*16-1:0]   in_imag,
    input  logic                  in_load,
    output logic                  in_ready,
    output logic                  in_overrun,
    output logic [WIDTH-1:0]      out_real,
    output logic [WIDTH-1:0]      out_imag,
    output logic [3:0]            out_bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
`ifdef FFT_REORDER_MAG_EN
    ,
    output logic [2*WIDTH-1:0]    out_mag
`endif
);

    typedef enum logic [0:0] {IDLE = 1'b0, STREAM = 1'b1} state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] real_buf_r [16];
    logic [WIDTH-1:0] imag_buf_r [16];
    logic [3:0]       cnt_r;
    logic             armed_r;
    logic             valid_r, last_r, overrun_r;
    logic [WIDTH-1:0] real_r, imag_r;
    logic             fire_s, done_s, ready_s, load_s;
    logic [3:0]       nxt_cnt_s, nxt_lane_s;

    function automatic logic [3:0] sel(input logic [3:0] k);
        if (BITREV != 0) begin
            return {k[0], k[1], k[2], k[3]};
        end else begin
            return k;
        end
    endfunction

`ifdef FFT_REORDER_MAG_EN
    logic [2*WIDTH-1:0] mag_r;

    // Sign-extend before squaring so the most negative value squares correctly.
    function automatic logic [2*WIDTH-1:0] mag(input logic [WIDTH-1:0] re, input logic [WIDTH-1:0] im);
        logic signed [2*WIDTH-1:0] re_x, im_x, rr, ii;
        re_x = {{WIDTH{re[WIDTH-1]}}, re};
        im_x = {{WIDTH{im[WIDTH-1]}}, im};
        rr   = re_x * re_x;
        ii   = im_x * im_x;
        return $unsigned(rr + ii);
    endfunction

    assign out_mag = mag_r;
`endif

    // Handshake decode and next-state selection.
    always_comb begin
        state_s    = state_r;
        fire_s     = valid_r && out_ready;
        done_s     = fire_s && last_r;
        ready_s    = armed_r && ((state_r == IDLE) || done_s);
        load_s     = in_load && ready_s;
        nxt_cnt_s  = cnt_r + 4'd1;
        nxt_lane_s = sel(nxt_cnt_s);
        case (state_r)
            IDLE: begin
                if (load_s) begin
                    state_s = STREAM;
                end else begin
                    state_s = IDLE;
                end
            end
            STREAM: begin
                if (load_s) begin
                    state_s = STREAM;
                end else if (done_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = STREAM;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Frame capture and beat datapath; bin 0 is lane 0 in either ordering, so it is taken straight from the input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < 16; j++) begin
                real_buf_r[j] <= '0;
                imag_buf_r[j] <= '0;
            end
            cnt_r     <= 4'd0;
            armed_r   <= 1'b0;
            valid_r   <= 1'b0;
            last_r    <= 1'b0;
            overrun_r <= 1'b0;
            real_r    <= '0;
            imag_r    <= '0;
`ifdef FFT_REORDER_MAG_EN
            mag_r     <= '0;
`endif
        end else begin
            armed_r   <= 1'b1;
            overrun_r <= in_load && !ready_s;
            if (load_s) begin
                for (int j = 0; j < 16; j++) begin
                    real_buf_r[j] <= in_real[j*WIDTH +: WIDTH];
                    imag_buf_r[j] <= in_imag[j*WIDTH +: WIDTH];
                end
                cnt_r   <= 4'd0;
                valid_r <= 1'b1;
                last_r  <= 1'b0;
                real_r  <= in_real[WIDTH-1:0];
                imag_r  <= in_imag[WIDTH-1:0];
`ifdef FFT_REORDER_MAG_EN
                mag_r   <= mag(in_real[WIDTH-1:0], in_imag[WIDTH-1:0]);
`endif
            end else if (done_s) begin
                valid_r <= 1'b0;
                last_r  <= 1'b0;
            end else if (fire_s) begin
                cnt_r   <= nxt_cnt_s;
                last_r  <= (cnt_r == 4'd14);
                real_r  <= real_buf_r[nxt_lane_s];
                imag_r  <= imag_buf_r[nxt_lane_s];
`ifdef FFT_REORDER_MAG_EN
                mag_r   <= mag(real_buf_r[nxt_lane_s], imag_buf_r[nxt_lane_s]);
`endif
            end else begin
                cnt_r   <= cnt_r;
            end
        end
    end

    assign in_ready   = ready_s;
    assign in_overrun = overrun_r;
    assign out_real   = real_r;
    assign out_imag   = imag_r;
    assign out_bin    = cnt_r;
    assign out_valid  = valid_r;
    assign out_last   = last_r;

endmodule
